// File: rtl/eviction_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : eviction_write_buffer
//  Purpose  : FIFO of evicted dirty cache lines between the L1 data cache and
//             physical memory. It takes a whole line per cycle, merges repeat
//             evictions of the same line, answers lookups, and drains one
//             line per memory burst.
//  Revision : 1.0 - initial release
// ============================================================================
module eviction_write_buffer #(
    parameter int BURST_W  = 128,
    parameter int ADDR_W   = 16,
    parameter int OFFSET_W = 4,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_push,
    input  logic [ADDR_W-1:0]  wb_push_addr,
    input  logic [BURST_W-1:0] wb_push_data,
    output logic               wb_full,
    output logic               wb_empty,
    output logic [CNT_W-1:0]   count,
    output logic               overflow,
    input  logic [ADDR_W-1:0]  lookup_addr,
    output logic               lookup_hit,
    output logic [BURST_W-1:0] lookup_data,
    input  logic               drain_pause,
    output logic               pmem_write,
    output logic [ADDR_W-1:0]  pmem_address,
    output logic [BURST_W-1:0] pmem_wdata,
    input  logic               pmem_resp
);

    localparam int c_LA_W  = ADDR_W - OFFSET_W;
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_DRAIN = 1'b1;

    // Entry storage
    logic [DEPTH-1:0]   valid_q;
    logic [c_LA_W-1:0]  line_q [DEPTH];
    logic [BURST_W-1:0] data_q [DEPTH];

    logic [c_PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q;
    logic [0:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pmem_addr_q, pmem_addr_d;
    logic [BURST_W-1:0] pmem_wdata_q, pmem_wdata_d;

    logic [c_LA_W-1:0]  w_push_line, w_look_line;
    logic [DEPTH-1:0]   w_coal_vec;
    logic               w_full, w_pop, w_coalesce, w_append, w_drop;

    // Offset bits of incoming addresses carry no information for a line buffer
    logic w_unused_offsets;
    assign w_unused_offsets = ^{wb_push_addr[OFFSET_W-1:0], lookup_addr[OFFSET_W-1:0]};

    assign w_push_line = wb_push_addr[ADDR_W-1:OFFSET_W];
    assign w_look_line = lookup_addr[ADDR_W-1:OFFSET_W];

    // The in-flight head is excluded from merging so its burst data stays stable
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_match
            assign w_coal_vec[g] = valid_q[g] && (line_q[g] == w_push_line) &&
                                   !((state_q == c_DRAIN) && (head_q == c_PTR_W'(g)));
        end
    endgenerate

    assign w_full     = (count_q == CNT_W'(DEPTH));
    assign w_pop      = (state_q == c_DRAIN) && pmem_resp;
    assign w_coalesce = wb_push && (|w_coal_vec);
    assign w_append   = wb_push && !(|w_coal_vec) && (!w_full || w_pop);
    assign w_drop     = wb_push && !(|w_coal_vec) && w_full && !w_pop;

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
        if (p == c_PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Entry update: append at tail wins over clearing a popped head (full + pop)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                line_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_append && (tail_q == c_PTR_W'(i))) begin
                    valid_q[i] <= 1'b1;
                    line_q[i]  <= w_push_line;
                    data_q[i]  <= wb_push_data;
                end else if (w_coalesce && w_coal_vec[i]) begin
                    data_q[i]  <= wb_push_data;
                end else if (w_pop && (head_q == c_PTR_W'(i))) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Occupancy follows appends and pops; merges leave it unchanged
    always_comb begin
        count_d = count_q;
        if (w_append && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_append && w_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers, occupancy and the sticky drop flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (w_append) tail_q <= next_ptr(tail_q);
            if (w_pop)    head_q <= next_ptr(head_q);
            count_q <= count_d;
            if (w_drop) overflow_q <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: the mandatory IDLE cycle between drains falls out of this
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if ((count_q != '0) && !drain_pause) state_d = c_DRAIN;
            c_DRAIN: if (pmem_resp) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // FSM outputs: capture the head line on entry to DRAIN, hold otherwise
    always_comb begin
        pmem_addr_d  = pmem_addr_q;
        pmem_wdata_d = pmem_wdata_q;
        if ((state_q == c_IDLE) && (state_d == c_DRAIN)) begin
            pmem_addr_d  = {line_q[head_q], {OFFSET_W{1'b0}}};
            pmem_wdata_d = data_q[head_q];
        end
    end

    // Burst address/data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
        end else begin
            pmem_addr_q  <= pmem_addr_d;
            pmem_wdata_q <= pmem_wdata_d;
        end
    end

    // Lookup walks oldest to youngest so the youngest match wins
    always_comb begin
        logic [c_PTR_W:0]   sum;
        logic [c_PTR_W-1:0] idx;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        sum         = '0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            sum = {1'b0, head_q} + (c_PTR_W + 1)'(k);
            if (sum >= (c_PTR_W + 1)'(DEPTH)) begin
                sum = sum - (c_PTR_W + 1)'(DEPTH);
            end
            idx = sum[c_PTR_W-1:0];
            if (valid_q[idx] && (line_q[idx] == w_look_line)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[idx];
            end
        end
    end

    assign wb_full      = w_full;
    assign wb_empty     = (count_q == '0);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign pmem_write   = (state_q == c_DRAIN);
    assign pmem_address = pmem_addr_q;
    assign pmem_wdata   = pmem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_eviction_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eviction_write_buffer
//  Purpose  : Directed self-checking bench for eviction_write_buffer
//  Revision : 1.0 - initial release
// ============================================================================
module tb_eviction_write_buffer;

    localparam int BURST_W = 128;
    localparam int ADDR_W  = 16;
    localparam int CNT_W   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               wb_push;
    logic [ADDR_W-1:0]  wb_push_addr;
    logic [BURST_W-1:0] wb_push_data;
    logic               wb_full, wb_empty, overflow;
    logic [CNT_W-1:0]   count;
    logic [ADDR_W-1:0]  lookup_addr;
    logic               lookup_hit;
    logic [BURST_W-1:0] lookup_data;
    logic               drain_pause;
    logic               pmem_write;
    logic [ADDR_W-1:0]  pmem_address;
    logic [BURST_W-1:0] pmem_wdata;
    logic               pmem_resp;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [BURST_W-1:0] D0 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [BURST_W-1:0] D1 = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;

    eviction_write_buffer #(
        .BURST_W(BURST_W), .ADDR_W(ADDR_W), .OFFSET_W(4), .DEPTH(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_push(wb_push), .wb_push_addr(wb_push_addr), .wb_push_data(wb_push_data),
        .wb_full(wb_full), .wb_empty(wb_empty), .count(count), .overflow(overflow),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .drain_pause(drain_pause),
        .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BURST_W-1:0] got,
                         input logic [BURST_W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] d);
        wb_push      = 1'b1;
        wb_push_addr = a;
        wb_push_data = d;
        step();
        wb_push      = 1'b0;
    endtask

    task automatic respond();
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
    endtask

    function automatic logic [BURST_W-1:0] mk(input logic [ADDR_W-1:0] a);
        return {a, 16'hA5A5, ~a, 16'h5A5A, a ^ 16'h1357, 16'hC3C3, a + 16'd7, 16'h0F0F};
    endfunction

    logic [ADDR_W-1:0] qa[$];
    logic [ADDR_W-1:0] na;

    initial begin
        rst = 1'b1; wb_push = 1'b0; wb_push_addr = '0; wb_push_data = '0;
        lookup_addr = '0; drain_pause = 1'b0; pmem_resp = 1'b0;
        #3;
        // Reset values
        check("rst_pmem_write", pmem_write, 0);
        check("rst_pmem_addr", pmem_address, 0);
        check("rst_pmem_wdata", pmem_wdata, 0);
        check("rst_count", count, 0);
        check("rst_empty", wb_empty, 1);
        check("rst_full", wb_full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_hit", lookup_hit, 0);
        #2 rst = 1'b0;
        step();

        // Basic push -> write -> response
        push(16'h1230, D0);
        check("t1_count", count, 1);
        check("t1_write_early", pmem_write, 0);
        step();
        check("t1_write", pmem_write, 1);
        check("t1_addr", pmem_address, 16'h1230);
        check("t1_wdata", pmem_wdata, D0);
        step(); step();
        check("t1_write_held", pmem_write, 1);
        respond();
        check("t1_write_done", pmem_write, 0);
        check("t1_count_done", count, 0);
        check("t1_empty", wb_empty, 1);

        // Coalesce while paused; resp outside DRAIN ignored
        drain_pause = 1'b1;
        push(16'h1234, D0);
        push(16'h123F, D1);
        check("t2_count", count, 1);
        lookup_addr = 16'h1238;
        #1;
        check("t2_hit", lookup_hit, 1);
        check("t2_data", lookup_data, D1);
        respond();
        check("t2_resp_ignored", count, 1);
        check("t2_paused", pmem_write, 0);
        drain_pause = 1'b0;
        step();
        check("t2_write", pmem_write, 1);
        check("t2_addr", pmem_address, 16'h1230);
        check("t2_wdata", pmem_wdata, D1);
        respond();
        check("t2_count_done", count, 0);
        step(); step();
        check("t2_single_write", pmem_write, 0);

        // Overflow and in-order drain
        for (int k = 0; k < 4; k++) push(16'h3000 + 16'(k * 16), mk(16'h3000 + 16'(k * 16)));
        check("t3_full", wb_full, 1);
        check("t3_count", count, 4);
        check("t3_no_ovf", overflow, 0);
        push(16'h3040, D0);
        check("t3_ovf", overflow, 1);
        check("t3_count_drop", count, 4);
        lookup_addr = 16'h3040;
        #1;
        check("t3_drop_miss", lookup_hit, 0);
        for (int k = 0; k < 4; k++) begin
            check("t3_write", pmem_write, 1);
            check("t3_addr", pmem_address, 16'h3000 + 16'(k * 16));
            check("t3_wdata", pmem_wdata, mk(16'h3000 + 16'(k * 16)));
            respond();
            check("t3_gap", pmem_write, 0);
            step();
        end
        check("t3_empty", wb_empty, 1);
        check("t3_ovf_sticky", overflow, 1);
        do_reset();
        check("t3_ovf_cleared", overflow, 0);

        // Push of the in-flight line appends rather than merging
        push(16'h2000, D0);
        step();
        check("t4_write", pmem_write, 1);
        push(16'h2000, D1);
        check("t4_count", count, 2);
        check("t4_wdata_stable", pmem_wdata, D0);
        lookup_addr = 16'h2000;
        #1;
        check("t4_lookup_hit", lookup_hit, 1);
        check("t4_lookup_new", lookup_data, D1);
        respond();
        check("t4_count_pop", count, 1);
        step();
        check("t4_write2", pmem_write, 1);
        check("t4_addr2", pmem_address, 16'h2000);
        check("t4_wdata2", pmem_wdata, D1);
        respond();
        check("t4_empty", count, 0);
        step();

        // Push accepted when full thanks to a same-cycle pop; pointer wrap
        qa.delete();
        for (int k = 0; k < 4; k++) begin
            push(16'h4000 + 16'(k * 16), mk(16'h4000 + 16'(k * 16)));
            qa.push_back(16'h4000 + 16'(k * 16));
        end
        check("t5_full", wb_full, 1);
        for (int r = 0; r < 12; r++) begin
            check("t5_write", pmem_write, 1);
            check("t5_addr", pmem_address, qa[0]);
            check("t5_wdata", pmem_wdata, mk(qa[0]));
            na = 16'h6000 + 16'(r * 16);
            wb_push = 1'b1; wb_push_addr = na; wb_push_data = mk(na);
            respond();
            wb_push = 1'b0;
            void'(qa.pop_front());
            qa.push_back(na);
            check("t5_count", count, 4);
            check("t5_no_ovf", overflow, 0);
            check("t5_idle", pmem_write, 0);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            check("t5_tail_write", pmem_write, 1);
            check("t5_tail_addr", pmem_address, qa[0]);
            check("t5_tail_wdata", pmem_wdata, mk(qa[0]));
            void'(qa.pop_front());
            respond();
            step();
        end
        check("t5_empty", wb_empty, 1);

        // Asynchronous reset in the middle of a drain
        push(16'h5000, D0);
        push(16'h5010, D1);
        check("t6_write", pmem_write, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_write", pmem_write, 0);
        check("t6_async_count", count, 0);
        lookup_addr = 16'h5000;
        #1;
        check("t6_async_hit", lookup_hit, 0);
        rst = 1'b0;
        step();
        check("t6_post_count", count, 0);
        check("t6_post_write", pmem_write, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
